// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 constants, host transmitter FSM encodings and parity helper.
package ps2_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_RTS       = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;

    localparam int PS2_FRAME_EDGES = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizers for the PS/2 clock/data lines plus a clock falling-edge strobe.
module ps2_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ck,
    input  logic i_dt,
    output logic o_ck,
    output logic o_dt,
    output logic o_fall
);

    logic [1:0] r_ck;
    logic [1:0] r_dt;
    logic       r_ck_d;

    // Idle PS/2 lines are high, so reset to 1 to avoid a spurious edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ck   <= 2'b11;
            r_dt   <= 2'b11;
            r_ck_d <= 1'b1;
        end else begin
            r_ck   <= {r_ck[0], i_ck};
            r_dt   <= {r_dt[0], i_dt};
            r_ck_d <= r_ck[1];
        end
    end

    assign o_ck   = r_ck[1];
    assign o_dt   = r_dt[1];
    assign o_fall = r_ck_d & ~r_ck[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (inhibit, request-to-send, 11-edge frame, ACK check).
// Define PS2_HOST_TX_TIMEOUT_EN to add a frame timeout from clock release to completion.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_MS = 20
)(
    input  logic       CLOCK,
    input  logic       reset,
    input  logic [7:0] txData,
    input  logic       txStart,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2ckIn,
    input  logic       ps2dtIn,
    output logic       ps2ckOe,
    output logic       ps2dtOe
);

    localparam int INHIBIT_CYCLES = CLK_HZ / 1000000 * INHIBIT_US;
    localparam int IW             = $clog2(INHIBIT_CYCLES + 1);

    logic [2:0]    r_state;
    logic [9:0]    r_shift;
    logic [IW-1:0] r_cnt;
    logic [3:0]    r_edges;
    logic          r_dt;
    logic          r_done;
    logic          r_err;
    logic          w_ck;
    logic          w_dt;
    logic          w_fall;
    logic          w_timeout;
    logic          w_in_frame;

    ps2_line_sync u_sync (
        .i_clk   (CLOCK),
        .i_rst_n (reset),
        .i_ck    (ps2ckIn),
        .i_dt    (ps2dtIn),
        .o_ck    (w_ck),
        .o_dt    (w_dt),
        .o_fall  (w_fall)
    );

    assign w_in_frame = (r_state == S_DATA) || (r_state == S_WAIT_IDLE);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int TO_CYCLES = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int TW        = $clog2(TO_CYCLES + 1);

    logic [TW-1:0] r_to;

    // Restarts at clock release, so it spans DATA entry through WAIT_IDLE
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset)
            r_to <= '0;
        else
            r_to <= (r_state == S_RTS) ? '0 : w_in_frame ? r_to + TW'(1) : r_to;
    end

    assign w_timeout = w_in_frame && (r_to == TW'(TO_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_edges <= '0;
            r_dt    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_timeout) begin
                r_state <= S_IDLE;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: if (txStart) begin
                        r_shift <= {1'b1, odd_parity(txData), txData};
                        r_cnt   <= '0;
                        r_edges <= '0;
                        r_state <= S_INHIBIT;
                    end
                    S_INHIBIT: begin
                        r_cnt   <= r_cnt + IW'(1);
                        r_state <= (r_cnt == IW'(INHIBIT_CYCLES - 1)) ? S_RTS : S_INHIBIT;
                    end
                    S_RTS: begin
                        r_dt    <= 1'b1;
                        r_state <= S_DATA;
                    end
                    S_DATA: if (w_fall) begin
                        r_edges <= (r_edges == 4'(PS2_FRAME_EDGES)) ? r_edges : r_edges + 4'd1;
                        // Edges 1..10 present data, parity, stop; edge 11 is the device ACK slot
                        if (r_edges == 4'(PS2_FRAME_EDGES - 1)) begin
                            r_state <= w_dt ? S_IDLE : S_WAIT_IDLE;
                            r_err   <= w_dt;
                        end else begin
                            r_dt    <= ~r_shift[0];
                            r_shift <= {1'b0, r_shift[9:1]};
                        end
                    end
                    S_WAIT_IDLE: if (w_ck && w_dt) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy    = r_state != S_IDLE;
    assign done    = r_done;
    assign error   = r_err;
    assign ps2ckOe = (r_state == S_INHIBIT) || (r_state == S_RTS);
    assign ps2dtOe = (r_state == S_RTS) || ((r_state == S_DATA) && r_dt);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a 12.5 kHz PS/2 device model (1 MHz system clock).
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int H = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       busy, done, error, ck_oe, dt_oe;
    logic       dev_ck = 1'b1;
    logic       dev_dt = 1'b1;
    logic       ck_line, dt_line;

    int total = 0;
    int bad = 0;
    int n_done = 0, n_err = 0, n_start = 0, n_both = 0;
    logic [2:0] err_snap = 3'b111;
    logic       busy_q = 1'b0;
    logic [9:0] got;

    assign ck_line = dev_ck & ~ck_oe;
    assign dt_line = dev_dt & ~dt_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.CLK_HZ(1000000), .INHIBIT_US(120), .TIMEOUT_MS(1)) dut (
        .CLOCK   (clk),
        .reset   (rst_n),
        .txData  (tx_data),
        .txStart (tx_start),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .ps2ckIn (ck_line),
        .ps2dtIn (dt_line),
        .ps2ckOe (ck_oe),
        .ps2dtOe (dt_oe)
    );

    always @(negedge clk) begin
        if (done) n_done++;
        if (error) begin
            n_err++;
            err_snap = {busy, ck_oe, dt_oe};
        end
        if (done && error) n_both++;
        if (busy && !busy_q) n_start++;
        busy_q = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_done = 0; n_err = 0; n_start = 0; n_both = 0; err_snap = 3'b111;
    endtask

    task automatic start(input logic [7:0] b);
        @(negedge clk);
        chk("idle_before_start", busy, 0);
        tx_data = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data = ~b;
        chk("busy_rise", busy, 1);
    endtask

    // Device: wait for RTS, then clock n edges; samples the host bit at the end of each low phase
    task automatic dev_frame(input bit ack, input int n, output logic [9:0] bits);
        int w = 0;
        bits = '0;
        while (!(ck_oe === 1'b0 && dt_oe === 1'b1) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("rts_seen", w < 5000, 1);
        if (w >= 5000) return;
        repeat (5) @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1 dev_ck = 1'b0;
            repeat (H) @(posedge clk);
            #1 if (k <= 10) bits[k-1] = dt_line;
            if (k == n && n < PS2_FRAME_EDGES) return;
            dev_ck = 1'b1;
            if (k == 11) dev_dt = 1'b1;
            repeat (H) @(posedge clk);
            #1 if (k == 10 && ack) dev_dt = 1'b0;
        end
    endtask

    initial begin
        int c;
        int t;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_ckoe", ck_oe, 0);
        chk("rst_dtoe", dt_oe, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0xF4 with inhibit length measurement and an ignored second start
        clr();
        start(PS2_CMD_ENABLE);
        c = 0;
        while (ck_oe && c < 1000) begin
            @(negedge clk);
            c++;
            if (c == 50) begin tx_data = 8'h00; tx_start = 1'b1; end
            if (c == 51) tx_start = 1'b0;
        end
        chk("ck_low_cycles", c, 121);
        chk("start_bit_held", dt_oe, 1);
        dev_frame(1'b1, 11, got);
        chk("f4_frame", got, 10'h2F4);
        repeat (200) @(negedge clk);
        chk("f4_done", n_done, 1);
        chk("f4_no_error", n_err, 0);
        chk("f4_one_frame", n_start, 1);
        chk("f4_busy_low", busy, 0);

        // Parity corner cases
        clr();
        start(8'h00);
        dev_frame(1'b1, 11, got);
        chk("x00_frame", got, 10'h300);
        repeat (20) @(negedge clk);
        chk("x00_done", n_done, 1);
        clr();
        start(PS2_CMD_RESET);
        dev_frame(1'b1, 11, got);
        chk("xff_frame", got, 10'h3FF);
        repeat (20) @(negedge clk);
        chk("xff_done", n_done, 1);
        chk("xff_no_error", n_err, 0);

        // NACK: device leaves data high at edge 11
        clr();
        start(PS2_CMD_SETLED);
        dev_frame(1'b0, 11, got);
        repeat (20) @(negedge clk);
        chk("nack_error", n_err, 1);
        chk("nack_no_done", n_done, 0);
        chk("nack_state_at_error", err_snap, 3'b000);
        chk("nack_busy", busy, 0);

        // Asynchronous reset in the middle of a frame
        clr();
        start(8'h00);
        dev_frame(1'b1, 5, got);
        chk("mid_dt_driven", dt_oe, 1);
        chk("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ckoe", ck_oe, 0);
        chk("arst_dtoe", dt_oe, 0);
        chk("arst_busy", busy, 0);
        dev_ck = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        clr();
        start(PS2_CMD_SETLED);
        dev_frame(1'b1, 11, got);
        chk("ed_frame", got, 10'h3ED);
        repeat (20) @(negedge clk);
        chk("ed_done", n_done, 1);
        chk("ed_no_error", n_err, 0);

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Silent device: error exactly 1000 cycles after DATA entry
        clr();
        start(PS2_CMD_ENABLE);
        c = 0;
        while (ck_oe && c < 1000) begin
            @(negedge clk);
            c++;
        end
        t = 0;
        while (!error && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("timeout_cycles", t, 1000);
        chk("timeout_no_done", n_done, 0);
        repeat (3) @(negedge clk);
        chk("timeout_busy", busy, 0);
`endif

        chk("never_done_and_error", n_both, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
